// File: rtl/risc16_pkg.sv
// risc16_pkg: constants and types shared by the program loader and the RISC16 core.
package risc16_pkg;
  localparam logic [7:0] LOADER_HDR = 8'hA5;
  localparam logic [5:0] HLT = 6'b111111;
  typedef enum logic [2:0] {L_IDLE, L_CNT, L_BASE, L_DATA, L_CHK, L_DONE, L_ERR} loader_state_e;
  function automatic logic is_waiting(loader_state_e s);
    return s inside {L_IDLE, L_DONE, L_ERR};
  endfunction
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream in, Mem write port and processor control out.
interface prog_loader_if #(parameter int ADDR_W = 10, parameter int DATA_W = 32);
  logic in_valid, in_ready, mem_we, cpu_halt, cpu_start, done, err;
  logic [7:0] in_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  modport master(input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata, cpu_halt, cpu_start, done, err);
  modport slave(output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata, cpu_halt, cpu_start, done, err);
endinterface

// File: rtl/prog_loader_word_packer.sv
// word_packer: shifts four big-endian bytes into one 32-bit word.
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);
  logic [23:0] shift_q;
  logic [1:0]  cnt_q;
  assign word_o = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i & (cnt_q == 2'd3);
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      shift_q <= '0;
      cnt_q <= '0;
    end else if (byte_valid_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q <= cnt_q + 2'd1;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: parses framed byte images into Mem and releases the halted core once the checksum verifies.
module prog_loader
  import risc16_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  prog_loader_if.master bus
);
  loader_state_e state_q;
  logic in_ready_q, mem_we_q, cpu_halt_q, cpu_start_q, done_q, err_q, sel_q;
  logic [ADDR_W-1:0] mem_addr_q, base_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [15:0] count_q, idx_q;
  logic [7:0] hi_q, xor_q, b;
  logic [31:0] word;
  logic word_valid, fire, hdr_hit, sum_ok;
  assign b = bus.in_data;
  assign fire = bus.in_valid & in_ready_q;
  assign hdr_hit = fire & is_waiting(state_q) & (b == LOADER_HDR);
  assign sum_ok = b == xor_q;
  word_packer u_packer (
    .clk(clk),
    .rst(rst),
    .clr_i(hdr_hit),
    .byte_valid_i(fire && state_q == L_DATA),
    .byte_i(b),
    .word_o(word),
    .word_valid_o(word_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= L_IDLE;
      in_ready_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      cpu_halt_q <= 1'b1;
      cpu_start_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      sel_q <= 1'b0;
      hi_q <= '0;
      count_q <= '0;
      base_q <= '0;
      idx_q <= '0;
      xor_q <= '0;
    end else begin
      in_ready_q <= 1'b1;
      mem_we_q <= 1'b0;
      cpu_start_q <= 1'b0;
      if (fire) begin
        if (state_q inside {L_CNT, L_BASE, L_DATA}) xor_q <= xor_q ^ b;
        case (state_q)
          L_CNT, L_BASE: begin
            // sel_q marks the low byte of a two-byte big-endian field
            sel_q <= ~sel_q;
            hi_q <= b;
            if (sel_q && state_q == L_CNT) begin
              count_q <= {hi_q, b};
              state_q <= L_BASE;
            end else if (sel_q) begin
              base_q <= ADDR_W'({hi_q, b});
              state_q <= (count_q == 16'd0) ? L_CHK : L_DATA;
            end
          end
          L_DATA: if (word_valid) begin
            mem_we_q <= 1'b1;
            mem_addr_q <= base_q + ADDR_W'(idx_q);
            mem_wdata_q <= word;
            idx_q <= idx_q + 16'd1;
            if (idx_q + 16'd1 == count_q) state_q <= L_CHK;
          end
          L_CHK: begin
            state_q <= sum_ok ? L_DONE : L_ERR;
            cpu_halt_q <= ~sum_ok;
            cpu_start_q <= sum_ok;
            done_q <= sum_ok;
            err_q <= ~sum_ok;
          end
          default: if (b == LOADER_HDR) begin
            state_q <= L_CNT;
            cpu_halt_q <= 1'b1;
            done_q <= 1'b0;
            err_q <= 1'b0;
            xor_q <= '0;
            idx_q <= '0;
            sel_q <= 1'b0;
          end
        endcase
      end
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_halt = cpu_halt_q;
  assign bus.cpu_start = cpu_start_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
endmodule
